// File: rtl/hazard_defs.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding selects, NOP.
// Also holds the forwarding priority function used for both ALU operands.
package hazard_defs;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StError   = 2'd2
  } state_e;

  localparam logic [1:0]  FWD_RF    = 2'b00;
  localparam logic [1:0]  FWD_WB    = 2'b01;
  localparam logic [1:0]  FWD_EXM   = 2'b10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // EX/MEM holds the newer result, so it is checked before MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic       exm_wr,
                                         input logic [4:0] exm_rd,
                                         input logic       wb_wr,
                                         input logic [4:0] wb_rd,
                                         input logic [4:0] rs);
    if (exm_wr && (exm_rd != 5'd0) && (exm_rd == rs)) begin
      return FWD_EXM;
    end else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i, holds at all-ones, cleared by async rst.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline (stalls, redirects, memory waits).
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined; otherwise tied to 0.
module hazard_ctrl
  import hazard_defs::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rs1_i,
  input  logic [4:0]       ex_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             redirect_valid_i,
  input  logic [4:0]       exm_rd_i,
  input  logic             exm_reg_write_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_reg_write_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_freeze_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             mem_timeout_err_o,
  output logic [CNT_W-1:0] perf_stall_cycles_o,
  output logic [CNT_W-1:0] perf_flushes_o,
  output logic [CNT_W-1:0] perf_freeze_cycles_o
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic load_use, mem_stall, freeze;

  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
  assign mem_stall = mem_access_i && !dmem_ready_i;

  assign freeze = (state_q == StError) ||
                  ((state_q == StMemWait) && !dmem_ready_i) ||
                  ((state_q == StRun) && mem_stall);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d = StMemWait;
          wait_d  = WaitW'(1);
        end
      end
      StMemWait: begin
        if (dmem_ready_i) begin
          state_d = StRun;
          wait_d  = '0;
        end else if (wait_q == WaitW'(MEM_TIMEOUT - 1)) begin
          state_d = StError;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StRun;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Mealy outputs; priority freeze > redirect > load-use > normal, all forced low in reset.
  always_comb begin
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    pipe_freeze_o  = 1'b0;
    fwd_a_o        = FWD_RF;
    fwd_b_o        = FWD_RF;
    if (!rst) begin
      fwd_a_o = fwd_sel(exm_reg_write_i, exm_rd_i, wb_reg_write_i, wb_rd_i, ex_rs1_i);
      fwd_b_o = fwd_sel(exm_reg_write_i, exm_rd_i, wb_reg_write_i, wb_rd_i, ex_rs2_i);
      if (freeze) begin
        pipe_freeze_o = 1'b1;
      end else if (redirect_valid_i) begin
        pc_write_o     = 1'b1;
        if_id_flush_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
      end else if (load_use) begin
        id_ex_bubble_o = 1'b1;
      end else begin
        pc_write_o    = 1'b1;
        if_id_write_o = 1'b1;
      end
    end
  end

  assign mem_timeout_err_o = (state_q == StError);

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc, flush_inc, freeze_inc;

  // A redirect also raises the bubble, so a stall cycle is a bubble without a flush.
  assign stall_inc  = id_ex_bubble_o && !if_id_flush_o;
  assign flush_inc  = if_id_flush_o;
  assign freeze_inc = pipe_freeze_o;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall_inc),
    .count_o (perf_stall_cycles_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (flush_inc),
    .count_o (perf_flushes_o)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (freeze_inc),
    .count_o (perf_freeze_cycles_o)
  );
`else
  assign perf_stall_cycles_o  = '0;
  assign perf_flushes_o       = '0;
  assign perf_freeze_cycles_o = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline.
- Drives the write, flush, bubble and freeze controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, the PC write enable, and the EX-stage forwarding selects.
- Resolves four conditions: load-use stalls, EX-stage branch/jump redirects, multi-cycle data-memory waits (with a watchdog), and forwarding.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive cycles dmem_ready may stay low before a fatal error (≥2).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rs1, ex_rs2  in  5  source registers held in ID/EX
- ex_rd  in  5  destination register in ID/EX
- ex_mem_read  in  1  ID/EX instruction is a load
- redirect_valid  in  1  EX resolved a taken branch or jump this cycle
- exm_rd  in  5  destination register in EX/MEM
- exm_reg_write  in  1  EX/MEM instruction writes the register file
- mem_access  in  1  EX/MEM instruction performs a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- wb_rd  in  5  destination register in MEM/WB
- wb_reg_write  in  1  MEM/WB instruction writes the register file
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  load NOP (0x00000013) into IF/ID
- id_ex_bubble  out  1  zero ID/EX controls (existing stall input)
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
- fwd_a, fwd_b  out  2  ALU operand select: 00 = register file, 01 = MEM/WB, 10 = EX/MEM
- mem_timeout_err  out  1  sticky fatal error
- perf_stall_cycles, perf_flushes, perf_freeze_cycles  out  CNT_W  performance counters

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN, with wait_cnt=0 and all counters 0.
- Reset output values while rst is high: all outputs 0.
- Definitions:
  - load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - mem_stall = mem_access & !dmem_ready.
- Outputs are Mealy, decided in the same cycle as the inputs. Priority is freeze > redirect > load-use > normal.
  - Freeze (state MEM_WAIT with !dmem_ready, or RUN with mem_stall): pipe_freeze=1, pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0. redirect_valid and load_use are ignored; they are re-presented after the unfreeze because their source stages are held.
  - Redirect: pc_write=1, if_id_write=0, if_id_flush=1, id_ex_bubble=1. This gives a 2-cycle penalty. A load-use hazard in the same cycle is discarded because the ID instruction is wrong-path.
  - Load-use: pc_write=0, if_id_write=0, id_ex_bubble=1. This gives exactly 1 bubble; next cycle ex_mem_read is 0 and the hazard clears.
  - Normal: pc_write=1, if_id_write=1, all other controls 0.
- Transitions:
  - RUN: mem_stall → MEM_WAIT with wait_cnt←1.
  - MEM_WAIT: dmem_ready → RUN with wait_cnt←0. Otherwise, if wait_cnt==MEM_TIMEOUT-1 → ERROR; else wait_cnt++.
  - ERROR: absorbing until rst.
- Timeout boundary: ready arriving in the MEM_TIMEOUT-th low cycle returns to RUN with no error. A MEM_TIMEOUT-th consecutive low cycle without ready enters ERROR at that edge.
- ERROR outputs: mem_timeout_err=1 (registered, = state==ERROR), pipe_freeze=1, pc_write=0, if_id_write=0, and flush/bubble 0. The state is left only by rst.
- Forwarding (combinational, independent of state):
  - fwd_a=10 if exm_reg_write & exm_rd!=0 & exm_rd==ex_rs1.
  - Else fwd_a=01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1.
  - Else fwd_a=00. fwd_b follows the same rules with ex_rs2.
  - When both stages match, EX/MEM (newer) wins.
- Asynchronous reset mid-MEM_WAIT: immediate return to RUN, counter cleared, outputs 0.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: saturating counters increment once per cycle.
  - perf_stall_cycles: on load-use-stall cycles.
  - perf_flushes: on redirect cycles.
  - perf_freeze_cycles: on freeze cycles, including ERROR.
  - Counters hold at all-ones and clear only on rst.
- Undefined: the ports remain and are tied to 0, and no counter flops are instantiated.

Decomposition:
- Shared package/include hazard_defs:
  - state encodings (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2);
  - FWD_RF/FWD_WB/FWD_EXM encodings;
  - NOP_INSTR=32'h00000013.
- One sub-module: sat_counter (parameter W, inputs clk, rst, inc; output count), instantiated three times under the macro.

Test Plan:
- Load-use: lw x5 in EX (ex_mem_read=1, ex_rd=5), ID uses rs1=5 → one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; the next cycle returns to normal; perf_stall_cycles=1.
- Redirect plus hazard: redirect_valid=1 in the same cycle as load_use → if_id_flush=1, id_ex_bubble=1, pc_write=1; perf_flushes=1 and perf_stall_cycles=0.
- Memory wait: mem_access=1 with dmem_ready low for 5 cycles, then high → pipe_freeze=1 for exactly 5 cycles, state returns to RUN, perf_freeze_cycles=5, no error.
- Timeout with MEM_TIMEOUT=16:
  - ready held low for 16 cycles → mem_timeout_err=1 from cycle 17, stays frozen, clears only on rst;
  - ready arriving in cycle 16 → no error.
- Forwarding:
  - exm_rd=wb_rd=ex_rs1=7, both writing → fwd_a=10;
  - exm_rd=0 → fwd_a=01;
  - wb_reg_write=0 → fwd_a=00.
- Reset mid-wait: assert rst in the 3rd MEM_WAIT cycle → all outputs 0 immediately; after release, state is RUN with counters 0.
